// File: rtl/fmul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Flag bit positions, qNaN payload pattern and operand classification.
package fmul_pkg;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef struct packed {
      logic is_zero;
      logic is_inf;
      logic is_nan;
      logic is_snan;
   } fclass_t;

   function automatic logic [63:0] qnan_frac(input int frac_w);
      return 64'(1) << (frac_w - 1);
   endfunction

   // Subnormals classify as zero; the fraction is ignored when exp is 0.
   function automatic fclass_t classify(input logic [63:0] ex,
                                        input logic [63:0] fr,
                                        input int          exp_w,
                                        input int          frac_w);
      logic [63:0] emask;
      logic [63:0] fmask;
      logic [63:0] msb;
      logic        e_zero;
      logic        e_ones;
      logic        f_zero;
      fclass_t     c;
      emask     = (64'(1) << exp_w) - 64'(1);
      fmask     = (64'(1) << frac_w) - 64'(1);
      msb       = fr >> (frac_w - 1);
      e_zero    = (ex & emask) == 64'(0);
      e_ones    = (ex & emask) == emask;
      f_zero    = (fr & fmask) == 64'(0);
      c.is_zero = e_zero;
      c.is_inf  = e_ones & f_zero;
      c.is_nan  = e_ones & ~f_zero;
      c.is_snan = e_ones & ~f_zero & ~msb[0];
      return c;
   endfunction

endpackage

// File: rtl/fmul_sig_mult.sv
// Unsigned significand multiplier, purely combinational.
// The parent registers the product; swap in a carry-save tree freely.
module fmul_sig_mult #(
   parameter int W = 24
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   assign p = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier with valid/ready and tag pass-through.
// Define FMUL_RNE_EN for round-to-nearest-even; otherwise truncates.
module fmul_pipe
   import fmul_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int TAG_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   a,
   input  logic [EXP_W+FRAC_W:0]   b,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic [TAG_W-1:0]        out_tag,
   output logic [3:0]              out_flags
);

   localparam int W  = EXP_W + FRAC_W + 1;
   localparam int MW = FRAC_W + 1;
   localparam int PW = 2 * MW;
   localparam int EW = EXP_W + 2;

   localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
   localparam logic [EW-1:0] EONE = EW'(1);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic             sign;
      logic             special;
      logic [W-1:0]     spec_res;
      logic             spec_inv;
      logic [EW-1:0]    exp;
      logic [MW-1:0]    ma;
      logic [MW-1:0]    mb;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic             sign;
      logic             special;
      logic [W-1:0]     spec_res;
      logic             spec_inv;
      logic [EW-1:0]    exp;
      logic [PW-1:0]    prod;
   } s2_t;

   s1_t              s1_q, s1_d;
   s2_t              s2_q, s2_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [3:0]       flags_q, flags_d;

   logic             advance;
   fclass_t          ca, cb;
   logic [W-1:0]     qnan;
   logic [PW-1:0]    prod_w;

   assign advance   = ~out_valid_q | out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_tag   = tag_q;
   assign out_flags = flags_q;

   assign qnan = {1'b0, {EXP_W{1'b1}}, FRAC_W'(qnan_frac(FRAC_W))};

   fmul_sig_mult #(.W(MW)) u_sig_mult (
      .a (s1_q.ma),
      .b (s1_q.mb),
      .p (prod_w)
   );

   // S1: classify, resolve specials, sign and biased exponent sum.
   always_comb begin
      ca   = classify(64'(a[W-2 -: EXP_W]), 64'(a[FRAC_W-1:0]),
                      EXP_W, FRAC_W);
      cb   = classify(64'(b[W-2 -: EXP_W]), 64'(b[FRAC_W-1:0]),
                      EXP_W, FRAC_W);
      s1_d = s1_q;
      if (advance) begin
         s1_d.valid    = in_valid;
         s1_d.tag      = in_tag;
         s1_d.sign     = a[W-1] ^ b[W-1];
         s1_d.exp      = {2'b00, a[W-2 -: EXP_W]}
                       + {2'b00, b[W-2 -: EXP_W]} - BIAS;
         s1_d.ma       = {1'b1, a[FRAC_W-1:0]};
         s1_d.mb       = {1'b1, b[FRAC_W-1:0]};
         s1_d.special  = 1'b1;
         s1_d.spec_inv = 1'b0;
         s1_d.spec_res = qnan;
         if (ca.is_nan | cb.is_nan) begin
            s1_d.spec_inv = ca.is_snan | cb.is_snan;
         end else if ((ca.is_inf & cb.is_zero) |
                      (cb.is_inf & ca.is_zero)) begin
            s1_d.spec_inv = 1'b1;
         end else if (ca.is_inf | cb.is_inf) begin
            s1_d.spec_res = {a[W-1] ^ b[W-1], {EXP_W{1'b1}},
                             {FRAC_W{1'b0}}};
         end else if (ca.is_zero | cb.is_zero) begin
            s1_d.spec_res = {a[W-1] ^ b[W-1], {(W-1){1'b0}}};
         end else begin
            s1_d.special  = 1'b0;
         end
      end
   end

   // S2: capture the significand product.
   always_comb begin
      s2_d = s2_q;
      if (advance) begin
         s2_d.valid    = s1_q.valid;
         s2_d.tag      = s1_q.tag;
         s2_d.sign     = s1_q.sign;
         s2_d.special  = s1_q.special;
         s2_d.spec_res = s1_q.spec_res;
         s2_d.spec_inv = s1_q.spec_inv;
         s2_d.exp      = s1_q.exp;
         s2_d.prod     = prod_w;
      end
   end

   logic [PW-1:0]     norm;
   logic [FRAC_W-1:0] frac;
   logic              r_bit;
   logic              s_bit;
   logic              inc;
   logic [FRAC_W:0]   rnd;
   logic [EW-1:0]     e_adj;
   logic              ovf;
   logic              unf;

   // S3: normalise so the leading one sits at the top, then round.
   always_comb begin
      norm  = s2_q.prod[PW-1] ? s2_q.prod : s2_q.prod << 1;
      frac  = norm[PW-2 -: FRAC_W];
      r_bit = norm[FRAC_W];
      s_bit = |norm[FRAC_W-1:0];
`ifdef FMUL_RNE_EN
      inc   = r_bit & (s_bit | frac[0]);
`else
      inc   = 1'b0;
`endif
      rnd   = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
      e_adj = s2_q.exp + EW'(s2_q.prod[PW-1]) + EW'(rnd[FRAC_W]);
      ovf   = $signed(e_adj) >= $signed(EMAX);
      unf   = $signed(e_adj) < $signed(EONE);

      out_valid_d = out_valid_q;
      result_d    = result_q;
      tag_d       = tag_q;
      flags_d     = flags_q;
      if (advance) begin
         out_valid_d = s2_q.valid;
         tag_d       = s2_q.tag;
         flags_d     = 4'b0000;
         if (s2_q.special) begin
            result_d                = s2_q.spec_res;
            flags_d[FLAG_INVALID]   = s2_q.spec_inv;
         end else if (ovf) begin
            result_d = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_d[FLAG_OVERFLOW]  = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
         end else if (unf) begin
            result_d = {s2_q.sign, {(W-1){1'b0}}};
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
         end else begin
            result_d = {s2_q.sign, e_adj[EXP_W-1:0], rnd[FRAC_W-1:0]};
            flags_d[FLAG_INEXACT]   = r_bit | s_bit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         tag_q       <= '0;
         flags_q     <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         tag_q       <= tag_d;
         flags_q     <= flags_d;
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: scoreboard queue, stall and reset checks.
// Expected products are hand-derived single-precision constants.
module tb_fmul_pipe;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  tag;
      logic [3:0]  flags;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  out_tag;
   logic [3:0]  out_flags;

   sb_t         sb[$];
   sb_t         mexp;
   int          checks = 0;
   int          errors = 0;
   int          outs   = 0;
   int          outs_snap;
   logic        stall_prev;
   logic [39:0] held;

`ifdef FMUL_RNE_EN
   localparam logic [31:0] RND_RES = 32'h3FC00002;
`else
   localparam logic [31:0] RND_RES = 32'h3FC00001;
`endif

   fmul_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag),
      .out_flags (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] av, input logic [31:0] bv,
                       input logic [3:0] t, input logic [31:0] er,
                       input logic [3:0] ef);
      logic hs;
      logic done;
      sb_t  e;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      in_tag   = t;
      done     = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         hs = in_ready;
         if (hs) begin
            e.res   = er;
            e.tag   = t;
            e.flags = ef;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
         done = hs;
      end
      checks++;
      assert (done) else begin
         errors++;
         $error("FAIL accept tag %0d observed not_accepted expected accepted",
                t);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
      #1;
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   // Output monitor: pops the scoreboard on every completed handshake.
   initial begin
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               checks++;
               assert ({result, out_tag, out_flags} === held) else begin
                  errors++;
                  $error("FAIL stall_hold observed %h expected %h",
                         {result, out_tag, out_flags}, held);
               end
            end
            if (out_valid && out_ready) begin
               outs++;
               checks++;
               assert (sb.size() > 0) else begin
                  errors++;
                  $error("FAIL spurious_out observed tag %0d expected none",
                         out_tag);
               end
               if (sb.size() > 0) begin
                  mexp = sb.pop_front();
                  checks++;
                  assert ({result, out_tag, out_flags} === mexp) else begin
                     errors++;
                     $error("FAIL result tag %0d observed %h/%h/%h expected %h/%h/%h",
                            mexp.tag, result, out_tag, out_flags,
                            mexp.res, mexp.tag, mexp.flags);
                  end
               end
            end
            stall_prev = out_valid && !out_ready;
            held       = {result, out_tag, out_flags};
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", result, 32'd0);
      chk("rst_tag", 32'(out_tag), 32'd0);
      chk("rst_flags", 32'(out_flags), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: output registers load on the third edge after acceptance.
      send(32'h3F800000, 32'h3F800000, 4'd1, 32'h3F800000, 4'b0000);
      in_valid = 1'b0;
      chk("lat_edge1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_edge2", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_edge3", 32'(out_valid), 32'd1);
      drain("drain_lat");

      send(32'h3FC00000, 32'h3FC00000, 4'd2, 32'h40100000, 4'b0000);
      send(32'hBFC00000, 32'h3FC00000, 4'd3, 32'hC0100000, 4'b0000);
      send(32'h3F800001, 32'h3FC00000, 4'd4, RND_RES,      4'b0001);
      send(32'h7F800000, 32'h00000000, 4'd5, 32'h7FC00000, 4'b1000);
      send(32'h7F800001, 32'h3F800000, 4'd6, 32'h7FC00000, 4'b1000);
      send(32'h7F7FFFFF, 32'h40000000, 4'd7, 32'h7F800000, 4'b0101);
      send(32'h00800000, 32'h00800000, 4'd8, 32'h00000000, 4'b0011);
      send(32'h00000001, 32'h3F800000, 4'd9, 32'h00000000, 4'b0000);
      send(32'h7FC00000, 32'h3F800000, 4'd10, 32'h7FC00000, 4'b0000);
      send(32'hFF800000, 32'h3F800000, 4'd11, 32'hFF800000, 4'b0000);
      send(32'h80000000, 32'h3F800000, 4'd12, 32'h80000000, 4'b0000);
      in_valid = 1'b0;
      drain("drain_vec");

      // Back-to-back stream with a 4-cycle downstream stall mid-stream.
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(32'h3F800000, 32'h40000000 | (32'(i) << 16), 4'(i),
                    32'h40000000 | (32'(i) << 16), 4'b0000);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #2 out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #2 chk("stall_in_ready", 32'(in_ready), 32'd0);
            repeat (2) @(posedge clk);
            #2 out_ready = 1'b1;
         end
      join
      drain("drain_stream");

      // Reset with work in flight: nothing may emerge afterwards.
      send(32'h3FC00000, 32'h3FC00000, 4'd13, 32'h40100000, 4'b0000);
      send(32'h3FC00000, 32'h3FC00000, 4'd14, 32'h40100000, 4'b0000);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      outs_snap = outs;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("postrst_outputs", 32'(outs), 32'(outs_snap));
      chk("postrst_out_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
